// File: rtl/avalon_pio_ctrl_pkg.sv
// pio_ctrl_pkg: register map, bus width and counter sizing shared by the PIO controller
package pio_ctrl_pkg;
    localparam int DATA_W = 32;
    localparam logic [2:0] ADDR_DATA_IN  = 3'd0;
    localparam logic [2:0] ADDR_LED_OUT  = 3'd1;
    localparam logic [2:0] ADDR_LED_SET  = 3'd2;
    localparam logic [2:0] ADDR_LED_CLR  = 3'd3;
    localparam logic [2:0] ADDR_IRQ_MASK = 3'd4;
    localparam logic [2:0] ADDR_EDGE_CAP = 3'd5;
    localparam logic [2:0] ADDR_RISE_EN  = 3'd6;
    localparam logic [2:0] ADDR_FALL_EN  = 3'd7;
    function automatic int cnt_w(input int n);
        return ($clog2(n + 1) < 1) ? 1 : $clog2(n + 1);
    endfunction
endpackage

// File: rtl/avalon_pio_ctrl_if.sv
// avalon_pio_ctrl_if: Avalon-MM slave bus bundle for the PIO controller
interface avalon_pio_ctrl_if;
    import pio_ctrl_pkg::*;
    logic [2:0]        avs_address;
    logic              avs_read;
    logic              avs_write;
    logic [DATA_W-1:0] avs_writedata;
    logic [DATA_W-1:0] avs_readdata;
    modport master (output avs_address, avs_read, avs_write, avs_writedata, input avs_readdata);
    modport slave  (input avs_address, avs_read, avs_write, avs_writedata, output avs_readdata);
endinterface

// File: rtl/avalon_pio_ctrl_debounce.sv
// pio_debounce: one switch channel - synchroniser, stability counter, debounced level and edge pulses
module pio_debounce
    import pio_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES  = 50000,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw,
    output logic d,
    output logic rise,
    output logic fall
);
    localparam int CW = cnt_w(DEB_CYCLES);
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   d_q, d_d, s, hit;
    assign s = sync_q[SYNC_STAGES-1];
    // hit marks the cycle whose closing edge commits the new level, so pulses align with d changing
    assign hit = (s != d_q) && (cnt_q == CW'(DEB_CYCLES - 1));
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], sw};
        cnt_d  = (s == d_q || hit) ? '0 : cnt_q + 1'b1;
        d_d    = hit ? s : d_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            cnt_q  <= '0;
            d_q    <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            d_q    <= d_d;
        end
    end
    assign d    = d_q;
    assign rise = hit & s;
    assign fall = hit & ~s;
endmodule

// File: rtl/avalon_pio_ctrl.sv
// avalon_pio_ctrl: Avalon-MM LED/switch PIO with debounced inputs, atomic LED updates and edge interrupts
module avalon_pio_ctrl
    import pio_ctrl_pkg::*;
#(
    parameter int SW_W        = 10,
    parameter int LED_W       = 10,
    parameter int DEB_CYCLES  = 50000,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk_clk,
    input  logic                reset_reset_n,
    avalon_pio_ctrl_if.slave    avs,
    input  logic [SW_W-1:0]     sw_in,
    output logic [LED_W-1:0]    led_out,
    output logic                irq
);
    logic [SW_W-1:0]   deb, rise_p, fall_p;
    logic [LED_W-1:0]  led_q, led_d;
    logic [SW_W-1:0]   mask_q, mask_d, cap_q, cap_d, rise_en_q, rise_en_d, fall_en_q, fall_en_d;
    logic [DATA_W-1:0] rdata_q, rdata_d, rmux;
    logic [2:0]        addr;
    logic              wr, unused_wd;
    assign addr      = avs.avs_address;
    assign wr        = avs.avs_write;
    assign unused_wd = ^avs.avs_writedata;
    for (genvar i = 0; i < SW_W; i++) begin : g_deb
        pio_debounce #(.DEB_CYCLES(DEB_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_deb (
            .clk   (clk_clk),
            .rst_n (reset_reset_n),
            .sw    (sw_in[i]),
            .d     (deb[i]),
            .rise  (rise_p[i]),
            .fall  (fall_p[i])
        );
    end
    always_comb begin
        led_d = (wr && addr == ADDR_LED_OUT) ? avs.avs_writedata[LED_W-1:0] :
                (wr && addr == ADDR_LED_SET) ? led_q | avs.avs_writedata[LED_W-1:0] :
                (wr && addr == ADDR_LED_CLR) ? led_q & ~avs.avs_writedata[LED_W-1:0] : led_q;
        mask_d    = (wr && addr == ADDR_IRQ_MASK) ? avs.avs_writedata[SW_W-1:0] : mask_q;
        rise_en_d = (wr && addr == ADDR_RISE_EN)  ? avs.avs_writedata[SW_W-1:0] : rise_en_q;
        fall_en_d = (wr && addr == ADDR_FALL_EN)  ? avs.avs_writedata[SW_W-1:0] : fall_en_q;
        // new captures are OR-ed in after the W1C so a coincident set survives
        cap_d = (cap_q & ~((wr && addr == ADDR_EDGE_CAP) ? avs.avs_writedata[SW_W-1:0] : '0))
              | (rise_p & rise_en_q) | (fall_p & fall_en_q);
        case (addr)
            ADDR_DATA_IN:  rmux = DATA_W'(deb);
            ADDR_LED_OUT:  rmux = DATA_W'(led_q);
            ADDR_IRQ_MASK: rmux = DATA_W'(mask_q);
            ADDR_EDGE_CAP: rmux = DATA_W'(cap_q);
            ADDR_RISE_EN:  rmux = DATA_W'(rise_en_q);
            ADDR_FALL_EN:  rmux = DATA_W'(fall_en_q);
            default:       rmux = '0;
        endcase
        rdata_d = avs.avs_read ? rmux : rdata_q;
    end
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            led_q     <= '0;
            mask_q    <= '0;
            cap_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            rdata_q   <= '0;
        end else begin
            led_q     <= led_d;
            mask_q    <= mask_d;
            cap_q     <= cap_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            rdata_q   <= rdata_d;
        end
    end
    assign led_out          = led_q;
    assign avs.avs_readdata = rdata_q;
    assign irq              = |(cap_q & mask_q);
endmodule

// File: doc/avalon_pio_ctrl.md
Name: avalon_pio_ctrl

Overview:
- Parametrised Avalon-MM slave that replaces the fixed 10-bit LED/switch PIO pair on the HPS lightweight bridge.
- Adds per-channel synchronisation and debounce of the switch inputs.
- Adds LED set/clear atomic writes and rising/falling edge capture with a maskable interrupt.
- Sits between the HPS-to-FPGA bridge and the board pins, in the same clock domain as the bridge.

Parameters:
- SW_W, 10, number of switch input channels (1..32).
- LED_W, 10, number of LED output channels (1..32).
- DEB_CYCLES, 50000, consecutive stable cycles required before the debounced value changes (≥1; 1 ms at 50 MHz).
- SYNC_STAGES, 2, flip-flop synchroniser depth on sw_in (≥2).

Ports:
- clk_clk  in  1  system clock.
- reset_reset_n  in  1  asynchronous active-low reset.
- avs_address  in  3  word address.
- avs_read  in  1  read strobe.
- avs_write  in  1  write strobe.
- avs_writedata  in  32  write data.
- avs_readdata  out  32  read data, fixed latency 1.
- sw_in  in  SW_W  raw asynchronous switch pins.
- led_out  out  LED_W  LED drive, registered.
- irq  out  1  level interrupt, active high.

Behaviour:
- Clocking and reset:
  - One clock. Reset is asynchronous and active-low.
  - Reset clears every flop: synchronisers, debounce counters, debounced value, all registers.
  - After reset, led_out=0, avs_readdata=0, irq=0.
  - Reset asserted mid-debounce or mid-read aborts the operation. No state survives.
- Register map (word address, access, reset value):
  - 0 DATA_IN, RO: debounced switches, zero-extended to 32 bits.
  - 1 LED_OUT, RW, 0: led_out mirrors this register.
  - 2 LED_SET, WO: LED_OUT |= wdata.
  - 3 LED_CLR, WO: LED_OUT &= ~wdata.
  - 4 IRQ_MASK, RW, 0.
  - 5 EDGE_CAP, R/W1C, 0.
  - 6 RISE_EN, RW, 0.
  - 7 FALL_EN, RW, 0.
- Bus rules:
  - No waitrequest.
  - Write takes effect at the clock edge where avs_write=1.
  - Read: avs_readdata is valid on the cycle after avs_read=1 and holds until the next read.
  - WO addresses read as 0. Bits above SW_W or LED_W read 0 and ignore writes.
  - avs_read and avs_write both high: the write is performed and the read returns the pre-write value.
- Debounce, per channel i:
  - s[i] = sw_in[i] after SYNC_STAGES flops. d[i] = debounced value. c[i] = counter of width clog2(DEB_CYCLES+1).
  - If s[i]==d[i]: c[i]<=0.
  - Else if c[i]==DEB_CYCLES-1: d[i]<=s[i] and c[i]<=0.
  - Else: c[i]<=c[i]+1.
  - A bounce (s returning to d) restarts the count.
  - Pin-to-DATA_IN latency for a clean step is SYNC_STAGES+DEB_CYCLES cycles.
- Edge capture:
  - EDGE_CAP[i] is set on the cycle d[i] changes 0→1 with RISE_EN[i]=1, or 1→0 with FALL_EN[i]=1.
  - EDGE_CAP bits are sticky until a 1 is written to them.
  - A set and a W1C on the same bit in the same cycle: set wins, bit stays 1.
  - Changing RISE_EN/FALL_EN does not alter already-captured bits.
- Interrupt:
  - irq = |(EDGE_CAP & IRQ_MASK), a combinational OR of registered state.
  - irq rises in the cycle after the capturing edge.
  - Masking a pending bit drops irq without clearing EDGE_CAP.
- Power-up: switches held high at reset release produce d 0→1. With RISE_EN=0 at reset, no spurious capture.

Decomposition:
- Package pio_ctrl_pkg holds:
  - address constants ADDR_DATA_IN..ADDR_FALL_EN (3-bit);
  - DATA_W=32;
  - a helper function for counter width.
- Sub-module pio_debounce (one channel): synchroniser, counter and debounced output, plus a one-cycle rise/fall pulse. Instantiated SW_W times in a generate loop.
- Top level holds the register file, edge/irq logic and read mux.

Test Plan:
- Bench parameters for all scenarios: SW_W=4, LED_W=4, DEB_CYCLES=4, SYNC_STAGES=2.
- Reset: assert reset_reset_n=0 mid-run → led_out=0, irq=0, readdata=0. After release, read all 8 addresses → all 0 except DATA_IN=sw debounced (0).
- LED atomics: write LED_OUT=0x5, then LED_SET=0x2, then LED_CLR=0x4 → led_out 0x5, 0x7, 0x3 on successive cycles. Read addr 1 → 0x3 one cycle after the read strobe.
- Debounce:
  - sw_in[0] toggles 0→1→0→1 at 2-cycle spacing, then holds 1 → DATA_IN[0] stays 0 during the bounce and reads 1 exactly 6 cycles after the final stable edge.
  - A 3-cycle glitch → no change.
- Edge/IRQ: RISE_EN=0x1, FALL_EN=0x2, IRQ_MASK=0x3; drive sw_in[0] rise and sw_in[1] fall → EDGE_CAP=0x3, irq=1. Write EDGE_CAP=0x1 → 0x2, irq stays 1. Write 0x2 → 0, irq=0.
- Collision: W1C of bit 0 issued in the same cycle that bit 0's debounced rise lands → EDGE_CAP[0]=1, irq=1.
- Mask/unmapped: pending EDGE_CAP=0x1 with IRQ_MASK=0 → irq=0. Read LED_SET address → 0. Write 0xFFFFFFFF to LED_OUT → read back 0xF.
